fir_mac_serial: RTL and testbench
=================================

Name: fir_mac_serial

Overview:
- Consumer end of the FIR tapped delay line: takes a snapshot of the parallel tap bus tp[0:ORDER] when a new sample has been shifted in.
- Computes sum(tp[k]*coef[k]) with a single time-multiplexed multiplier-accumulator over ORDER+1 cycles.
- Rounds, optionally saturates, and presents one filtered sample with a one-cycle valid strobe.
- Sits between the delay line and the downstream decimation/output stage.

Parameters:
- DATA_WIDTH, 13, signed sample and tap width
- COEF_WIDTH, 13, signed coefficient width (Q1.(COEF_WIDTH-1))
- ORDER, 8, filter order; ORDER+1 taps
- OUT_WIDTH, 16, signed output width
- ACC_WIDTH, DATA_WIDTH+COEF_WIDTH+$clog2(ORDER+1), accumulator width
- SHIFT, COEF_WIDTH-1, right shift applied to the accumulator before output

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  asynchronous, active-high reset
- VIN  input  1  strobe: tp holds a new valid tap set this cycle
- tp  input  signed [DATA_WIDTH-1:0] x [0:ORDER]  tap bus from the delay line
- coef  input  signed [COEF_WIDTH-1:0] x [0:ORDER]  coefficients; static while BUSY
- BUSY  output  1  high whenever the state is not IDLE
- VOUT  output  1  one-cycle pulse: DOUT is valid
- DOUT  output  signed [OUT_WIDTH-1:0]  filtered sample; held until the next VOUT
- DROP  output  1  one-cycle pulse: VIN ignored because the block was busy

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, k=0, acc=0, snapshot regs=0, BUSY=0, VOUT=0, DOUT=0, DROP=0.
- Reset asserted mid-computation aborts the computation; no VOUT is produced.
- States: IDLE, MAC, DONE.
- IDLE: on a rising edge with VIN=1:
  - copy tp[0:ORDER] into the internal snapshot;
  - acc<=0, k<=0, state<=MAC.
- MAC: each edge, acc <= acc + snap[k]*coef[k].
  - Full-precision signed product, sign-extended to ACC_WIDTH.
  - k increments each edge. When k==ORDER, the last product is added and state<=DONE.
  - Exactly ORDER+1 MAC edges.
- DONE: one edge; r = (acc + 2^(SHIFT-1)) >>> SHIFT (arithmetic shift, round-half-up).
  - DOUT <= fit(r) to OUT_WIDTH (see Optional Feature).
  - VOUT <= 1 for exactly one cycle; state <= IDLE.
- Latency: VIN sampled at edge E0 -> VOUT high after edge E0+ORDER+2 (E0+10 for ORDER=8).
- Throughput: one result per ORDER+3 cycles.
- VIN sampled while in MAC or DONE:
  - ignored, and the snapshot is not disturbed;
  - DROP pulses for one cycle on the next edge.
- VIN in the IDLE cycle directly after VOUT is accepted normally.
- tp changing after the capture edge has no effect on the result.
- coef changing while BUSY gives an undefined result; the bench must hold coef stable.
- VOUT and DROP are registered; there are no combinational input-to-output paths.

Optional Feature:
- Macro: FIR_MAC_SAT_EN.
- Defined: fit() saturates.
  - r > 2^(OUT_WIDTH-1)-1 -> DOUT = 2^(OUT_WIDTH-1)-1.
  - r < -2^(OUT_WIDTH-1) -> DOUT = -2^(OUT_WIDTH-1).
  - Otherwise DOUT = r.
- Undefined: fit() keeps the low OUT_WIDTH bits of r (two's-complement wrap), with no saturation logic.
- All other behaviour, including latency, is identical in both builds.

Test Plan:
- Uniform: all coef=2048, all tp=100, VIN pulse -> VOUT exactly 10 edges later, DOUT=450; BUSY high for 10 cycles, DROP=0.
- Impulse: tp[3]=4095, coef[3]=4095, all others 0 -> DOUT=4094; changing tp during MAC leaves DOUT=4094.
- Positive overflow: all tp=4095, all coef=4095.
  - With FIR_MAC_SAT_EN -> DOUT=32767.
  - Without -> DOUT=-28690.
- Negative overflow: all tp=-4096, all coef=4095.
  - With FIR_MAC_SAT_EN -> DOUT=-32768.
  - Without -> DOUT=-36855 wrapped to 28681.
- Busy collision: VIN at E0 and again at E0+4 -> single VOUT at E0+10 with the E0 result; DROP pulse after E0+4. VIN at E0+11 is accepted (VOUT at E0+21).
- Reset mid-op: RST pulsed at E0+5 -> BUSY, VOUT, DOUT and DROP go 0 immediately with no VOUT afterwards; a fresh VIN then produces a correct result.

Source files
------------

// File: rtl/fir_mac_serial_if.sv
`default_nettype none
// =============================================================================
// Module      : fir_mac_serial_if
// Description : Tap-bus / result bundle between the FIR delay line, the serial
//               MAC (slave) and whatever drives it (master).
// Revision    : 1.0  initial release
// =============================================================================
interface fir_mac_serial_if #(
    parameter int DATA_WIDTH = 13,
    parameter int COEF_WIDTH = 13,
    parameter int ORDER      = 8,
    parameter int OUT_WIDTH  = 16
);
    logic                         VIN;
    logic signed [DATA_WIDTH-1:0] tp   [0:ORDER];
    logic signed [COEF_WIDTH-1:0] coef [0:ORDER];
    logic                         BUSY;
    logic                         VOUT;
    logic signed [OUT_WIDTH-1:0]  DOUT;
    logic                         DROP;

    modport master (
        output VIN, tp, coef,
        input  BUSY, VOUT, DOUT, DROP
    );

    modport slave (
        input  VIN, tp, coef,
        output BUSY, VOUT, DOUT, DROP
    );
endinterface
`default_nettype wire

// File: rtl/fir_mac_serial.sv
`default_nettype none
// =============================================================================
// Module      : fir_mac_serial
// Description : Snapshots the FIR tap bus on VIN, accumulates sum(tp[k]*coef[k])
//               with one multiplier over ORDER+1 cycles, rounds half-up,
//               shifts by SHIFT and emits one sample with a VOUT strobe.
//               Build option: define FIR_MAC_SAT_EN to saturate the output
//               instead of wrapping it to OUT_WIDTH bits.
// Revision    : 1.0  initial release
// =============================================================================
module fir_mac_serial #(
    parameter int DATA_WIDTH = 13,
    parameter int COEF_WIDTH = 13,
    parameter int ORDER      = 8,
    parameter int OUT_WIDTH  = 16,
    parameter int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + $clog2(ORDER + 1),
    parameter int SHIFT      = COEF_WIDTH - 1
) (
    input  wire logic         CLK,
    input  wire logic         RST,
    fir_mac_serial_if.slave   bus
);

    localparam int K_WIDTH = (ORDER > 0) ? $clog2(ORDER + 1) : 1;
    localparam int PROD_W  = DATA_WIDTH + COEF_WIDTH;

    localparam logic [K_WIDTH-1:0]      C_K_LAST = K_WIDTH'(ORDER);
    // Half an output LSB, added before the arithmetic shift for round-half-up.
    localparam logic signed [ACC_WIDTH:0] C_RND  = (ACC_WIDTH + 1)'(1) <<< (SHIFT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                       state_q, state_d;
    logic [K_WIDTH-1:0]           k_q, k_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic signed [DATA_WIDTH-1:0] snap_q [0:ORDER];
    logic signed [DATA_WIDTH-1:0] snap_d [0:ORDER];
    logic signed [OUT_WIDTH-1:0]  dout_q, dout_d;
    logic                         vout_q, vout_d;
    logic                         drop_q, drop_d;

    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_WIDTH:0]    rnd_sum;
    logic signed [OUT_WIDTH-1:0]  dout_fit;

    // Full-precision product of the tap/coefficient pair selected by k.
    assign prod    = PROD_W'(snap_q[k_q]) * PROD_W'(bus.coef[k_q]);
    // One guard bit so adding the rounding constant can never overflow.
    assign rnd_sum = {acc_q[ACC_WIDTH-1], acc_q} + C_RND;

`ifdef FIR_MAC_SAT_EN
    localparam logic signed [ACC_WIDTH:0] C_OUT_MAX =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] C_OUT_MIN =
        {{(ACC_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [ACC_WIDTH:0] r_full;
    assign r_full = rnd_sum >>> SHIFT;

    // Clamp the rounded result to the signed OUT_WIDTH range.
    always_comb begin
        dout_fit = r_full[OUT_WIDTH-1:0];
        if (r_full > C_OUT_MAX) begin
            dout_fit = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
        end else if (r_full < C_OUT_MIN) begin
            dout_fit = {1'b1, {(OUT_WIDTH - 1){1'b0}}};
        end
    end
`else
    // Two's-complement wrap: keep only the low OUT_WIDTH bits of the result.
    assign dout_fit = OUT_WIDTH'(rnd_sum >>> SHIFT);
`endif

    // Next-state and datapath control for the IDLE -> MAC -> DONE sequence.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        acc_d   = acc_q;
        snap_d  = snap_q;
        dout_d  = dout_q;
        vout_d  = 1'b0;
        drop_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.VIN) begin
                    snap_d  = bus.tp;
                    acc_d   = '0;
                    k_d     = '0;
                    state_d = ST_MAC;
                end
            end
            ST_MAC: begin
                acc_d = acc_q + ACC_WIDTH'(prod);
                if (k_q == C_K_LAST) begin
                    k_d     = '0;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_DONE: begin
                dout_d  = dout_fit;
                vout_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new tap set arriving while busy is discarded and flagged.
        if (bus.VIN && (state_q != ST_IDLE)) begin
            drop_d = 1'b1;
        end
    end

    // State, accumulator, snapshot and output registers; reset aborts any run.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            acc_q   <= '0;
            for (int i = 0; i <= ORDER; i++) begin
                snap_q[i] <= '0;
            end
            dout_q  <= '0;
            vout_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            acc_q   <= acc_d;
            snap_q  <= snap_d;
            dout_q  <= dout_d;
            vout_q  <= vout_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.BUSY = (state_q != ST_IDLE);
    assign bus.VOUT = vout_q;
    assign bus.DOUT = dout_q;
    assign bus.DROP = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_fir_mac_serial.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// Module      : tb_fir_mac_serial
// Description : Scoreboard bench for fir_mac_serial. Stimulus pushes the
//               hand-computed result and its due cycle; a monitor pops and
//               compares on every VOUT. Honours FIR_MAC_SAT_EN.
// Revision    : 1.0  initial release
// =============================================================================
module tb_fir_mac_serial;

    localparam int DW  = 13;
    localparam int CW  = 13;
    localparam int ORD = 8;
    localparam int OW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fir_mac_serial_if #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .ORDER(ORD), .OUT_WIDTH(OW)) bus ();

    fir_mac_serial #(.DATA_WIDTH(DW), .COEF_WIDTH(CW), .ORDER(ORD), .OUT_WIDTH(OW)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic signed [OW-1:0] exp_q [$];
    int                   due_q [$];
    logic signed [OW-1:0] mon_exp;
    int                   mon_due;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every VOUT must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (bus.VOUT) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vout: VOUT at cycle %0d with nothing outstanding, DOUT=%0d",
                         cyc, bus.DOUT);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_due = due_q.pop_front();
                checks++;
                if (bus.DOUT !== mon_exp) begin
                    errors++;
                    $display("FAIL dout_value: got %0d, expected %0d (cycle %0d)", bus.DOUT, mon_exp, cyc);
                end
                checks++;
                if (cyc != mon_due) begin
                    errors++;
                    $display("FAIL vout_latency: VOUT at cycle %0d, expected cycle %0d", cyc, mon_due);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, expv);
        end
    endtask

    task automatic set_tp(input int v);
        for (int i = 0; i <= ORD; i++) bus.tp[i] = DW'(v);
    endtask

    task automatic set_coef(input int v);
        for (int i = 0; i <= ORD; i++) bus.coef[i] = CW'(v);
    endtask

    // Called at a negedge; VIN is sampled on the following rising edge E0 and
    // the result must appear after edge E0+ORD+2.
    task automatic issue(input logic signed [OW-1:0] e);
        bus.VIN = 1'b1;
        exp_q.push_back(e);
        due_q.push_back(cyc + 1 + ORD + 2);
        @(negedge clk);
        bus.VIN = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL result_timeout: %0d results still outstanding", exp_q.size());
            exp_q.delete();
            due_q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    int busy_cnt;
    int drop_cnt;

    initial begin
        bus.VIN = 1'b0;
        set_tp(0);
        set_coef(0);
        repeat (3) @(negedge clk);
        chk("reset_busy", int'(bus.BUSY), 0);
        chk("reset_vout", int'(bus.VOUT), 0);
        chk("reset_dout", int'(bus.DOUT), 0);
        chk("reset_drop", int'(bus.DROP), 0);
        rst = 1'b0;
        @(negedge clk);

        // Uniform: 9*100*2048 / 4096 = 450
        set_tp(100);
        set_coef(2048);
        issue(16'sd450);
        busy_cnt = 0;
        drop_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.BUSY) busy_cnt++;
            if (bus.DROP) drop_cnt++;
            @(negedge clk);
        end
        chk("uniform_busy_cycles", busy_cnt, 10);
        chk("uniform_drop_count", drop_cnt, 0);
        wait_done();

        // Impulse: 4095*4095 = 16769025, rounded >>> 12 = 4094; tp changes after capture
        set_tp(0);
        bus.tp[3] = 13'sd4095;
        set_coef(0);
        bus.coef[3] = 13'sd4095;
        @(negedge clk);
        issue(16'sd4094);
        set_tp(4095);
        bus.tp[3] = -13'sd4096;
        wait_done();

        // Positive overflow: r = 36846
        set_tp(4095);
        set_coef(4095);
`ifdef FIR_MAC_SAT_EN
        issue(16'sd32767);
`else
        issue(-16'sd28690);
`endif
        wait_done();

        // Negative overflow: r = -36855
        set_tp(-4096);
`ifdef FIR_MAC_SAT_EN
        issue(-16'sd32768);
`else
        issue(16'sd28681);
`endif
        wait_done();

        // Busy collision: second VIN at E0+4 is dropped, snapshot untouched
        set_tp(100);
        set_coef(2048);
        issue(16'sd450);
        set_tp(7);
        repeat (3) @(negedge clk);
        bus.VIN = 1'b1;
        @(negedge clk);
        bus.VIN = 1'b0;
        chk("collision_drop_pulse", int'(bus.DROP), 1);
        @(negedge clk);
        chk("collision_drop_clear", int'(bus.DROP), 0);
        set_tp(50);
        repeat (5) @(negedge clk);
        // VIN sampled at E0+11, the idle cycle right after VOUT: 9*50*2048/4096 = 225
        issue(16'sd225);
        wait_done();

        // Reset mid-computation: -9*100*2048/4096 = -450 (exact, round-half-up keeps it)
        set_tp(-100);
        issue(-16'sd450);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        exp_q.delete();
        due_q.delete();
        chk("midreset_busy", int'(bus.BUSY), 0);
        chk("midreset_vout", int'(bus.VOUT), 0);
        chk("midreset_dout", int'(bus.DOUT), 0);
        chk("midreset_drop", int'(bus.DROP), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        issue(-16'sd450);
        wait_done();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
